// File: rtl/block_exp_detect.sv
// block_exp_detect: buffers one frame, finds the minimum redundant sign bits, replays it with shift_value.
// Defining BLOCK_EXP_GUARD_EN reduces shift_value by one to leave a headroom bit.
module block_exp_detect #(
    parameter int DATA_WIDTH  = 23,
    parameter int SHIFT_WIDTH = 5,
    parameter int FRAME_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_re,
    input  logic [DATA_WIDTH-1:0]  in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_re,
    output logic [DATA_WIDTH-1:0]  out_im,
    output logic                   out_last,
    output logic [SHIFT_WIDTH-1:0] shift_value
);
    localparam int AW   = $clog2(FRAME_LEN);
    localparam int RW   = $clog2(DATA_WIDTH);
    localparam int SMAX = 2**SHIFT_WIDTH - 1;
    typedef enum logic {COLLECT, DRAIN} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [RW-1:0] min_q, min_d, rsb_re, rsb_im, smp_min, fin_min;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d, sat, guarded;
    logic [2*DATA_WIDTH-1:0] mem_q [FRAME_LEN];
    logic wr_en, last_in, rd_fire, last_out;

    function automatic logic [RW-1:0] rsb(input logic [DATA_WIDTH-1:0] x);
        logic done;
        rsb = '0;
        done = 1'b0;
        for (int i = DATA_WIDTH-2; i >= 0; i--) begin
            if (!done && x[i] == x[DATA_WIDTH-1]) rsb = rsb + RW'(1);
            else done = 1'b1;
        end
    endfunction

    always_comb begin
        rsb_re   = rsb(in_re);
        rsb_im   = rsb(in_im);
        smp_min  = rsb_re < rsb_im ? rsb_re : rsb_im;
        fin_min  = smp_min < min_q ? smp_min : min_q;
        sat      = int'(fin_min) > SMAX ? SHIFT_WIDTH'(SMAX) : SHIFT_WIDTH'(fin_min);
`ifdef BLOCK_EXP_GUARD_EN
        guarded  = sat == '0 ? '0 : sat - SHIFT_WIDTH'(1);
`else
        guarded  = sat;
`endif
        wr_en    = state_q == COLLECT && in_valid;
        last_in  = wr_en && wr_q == AW'(FRAME_LEN-1);
        rd_fire  = state_q == DRAIN && out_ready;
        last_out = rd_fire && rd_q == AW'(FRAME_LEN-1);
        state_d  = last_in ? DRAIN : last_out ? COLLECT : state_q;
        wr_d     = wr_en ? wr_q + AW'(1) : wr_q;
        rd_d     = rd_fire ? rd_q + AW'(1) : rd_q;
        min_d    = last_in ? '1 : wr_en ? fin_min : min_q;
        shift_d  = last_in ? guarded : shift_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            wr_q    <= '0;
            rd_q    <= '0;
            min_q   <= '1;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            min_q   <= min_d;
            shift_q <= shift_d;
        end
    end

    // Buffer is not reset; reads are masked outside DRAIN.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= {in_re, in_im};
    end

    assign in_ready    = state_q == COLLECT;
    assign out_valid   = state_q == DRAIN;
    assign out_re      = out_valid ? mem_q[rd_q][2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign out_im      = out_valid ? mem_q[rd_q][DATA_WIDTH-1:0] : '0;
    assign out_last    = out_valid && rd_q == AW'(FRAME_LEN-1);
    assign shift_value = shift_q;
endmodule

// File: tb/tb_block_exp_detect.sv
// tb_block_exp_detect: directed scenario tasks with hand-computed shift values and replay checks.
module tb_block_exp_detect;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [22:0] in_re, in_im, out_re, out_im;
    logic [4:0] shift_value;
    logic [22:0] vre [16], vim [16], cre [16], cim [16];
    logic clast [16];
    int ncap;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    block_exp_detect dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last), .shift_value(shift_value)
    );

    function automatic logic [4:0] ex(input int v);
`ifdef BLOCK_EXP_GUARD_EN
        return 5'(v > 0 ? v - 1 : 0);
`else
        return 5'(v);
`endif
    endfunction

    task automatic send_frame();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re = vre[i];
            in_im = vim[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
    endtask

    task automatic drain_all();
        ncap = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && ncap < 16; c++) begin
            if (out_valid) begin
                cre[ncap] = out_re;
                cim[ncap] = out_im;
                clast[ncap] = out_last;
                ncap++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_re = '0;
        in_im = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || shift_value !== 5'd0 || out_last !== 1'b0 || out_re !== '0 || out_im !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b shift=%0d last=%b re=%h im=%h want 1 0 0 0 0 0",
                     in_ready, out_valid, shift_value, out_last, out_re, out_im);
        end
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || shift_value !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b vld=%b shift=%0d want 1 0 0", in_ready, out_valid, shift_value);
        end
    endtask

    task automatic test_frame_fff();
        for (int i = 0; i < 16; i++) begin
            vre[i] = 23'(i + 1);
            vim[i] = '0;
        end
        vre[5] = 23'h000FFF;
        send_frame();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fff_latency got vld=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        checks++;
        if (shift_value !== ex(10)) begin
            errors++;
            $display("FAIL fff_shift got %0d want %0d", shift_value, ex(10));
        end
        drain_all();
        checks++;
        if (ncap !== 16) begin
            errors++;
            $display("FAIL fff_count got %0d want 16", ncap);
        end
        for (int i = 0; i < ncap; i++) begin
            checks++;
            if (cre[i] !== vre[i] || cim[i] !== vim[i] || clast[i] !== (i == 15)) begin
                errors++;
                $display("FAIL fff_sample%0d got %h/%h/%b want %h/%h/%b", i, cre[i], cim[i], clast[i], vre[i], vim[i], i == 15);
            end
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || shift_value !== ex(10)) begin
            errors++;
            $display("FAIL fff_after got rdy=%b vld=%b shift=%0d want 1 0 %0d", in_ready, out_valid, shift_value, ex(10));
        end
    endtask

    task automatic test_zero();
        for (int i = 0; i < 16; i++) begin
            vre[i] = '0;
            vim[i] = '0;
        end
        send_frame();
        checks++;
        if (shift_value !== ex(22)) begin
            errors++;
            $display("FAIL zero_shift got %0d want %0d", shift_value, ex(22));
        end
        drain_all();
        vim[3] = 23'h7FFFFF;
        send_frame();
        checks++;
        if (shift_value !== ex(22)) begin
            errors++;
            $display("FAIL minus1_shift got %0d want %0d", shift_value, ex(22));
        end
        drain_all();
        checks++;
        if (ncap !== 16 || cim[3] !== 23'h7FFFFF) begin
            errors++;
            $display("FAIL minus1_replay got n=%0d im3=%h want 16 7fffff", ncap, cim[3]);
        end
    endtask

    task automatic test_neg_full();
        for (int i = 0; i < 16; i++) begin
            vre[i] = 23'(i);
            vim[i] = '0;
        end
        vim[7] = 23'h400000;
        send_frame();
        checks++;
        if (shift_value !== 5'd0) begin
            errors++;
            $display("FAIL negfull_shift got %0d want 0", shift_value);
        end
        drain_all();
        checks++;
        if (ncap !== 16 || cim[7] !== 23'h400000 || cre[7] !== 23'd7) begin
            errors++;
            $display("FAIL negfull_replay got n=%0d re7=%h im7=%h want 16 000007 400000", ncap, cre[7], cim[7]);
        end
    endtask

    task automatic test_backpressure();
        int stall;
        for (int i = 0; i < 16; i++) begin
            vre[i] = 23'(32'h100 + i);
            vim[i] = 23'(32'h200 + i);
        end
        send_frame();
        ncap = 0;
        stall = 0;
        for (int c = 0; c < 200 && ncap < 16; c++) begin
            out_ready = !(ncap == 5 && stall < 3);
            if (!out_ready) begin
                stall++;
                checks++;
                if (out_re !== vre[5] || out_im !== vim[5] || out_last !== 1'b0 || shift_value !== ex(12) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold%0d got re=%h im=%h last=%b shift=%0d rdy=%b vld=%b want %h %h 0 %0d 0 1",
                             stall, out_re, out_im, out_last, shift_value, in_ready, out_valid, vre[5], vim[5], ex(12));
                end
            end else if (out_valid) begin
                cre[ncap] = out_re;
                cim[ncap] = out_im;
                clast[ncap] = out_last;
                ncap++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (ncap !== 16 || stall !== 3) begin
            errors++;
            $display("FAIL bp_count got n=%0d stalls=%0d want 16 3", ncap, stall);
        end
        for (int i = 0; i < ncap; i++) begin
            checks++;
            if (cre[i] !== vre[i] || cim[i] !== vim[i] || clast[i] !== (i == 15)) begin
                errors++;
                $display("FAIL bp_sample%0d got %h/%h/%b want %h/%h/%b", i, cre[i], cim[i], clast[i], vre[i], vim[i], i == 15);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re = 23'h3FFFFF;
            in_im = 23'h3FFFFF;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || shift_value !== 5'd0) begin
            errors++;
            $display("FAIL midrst_state got rdy=%b vld=%b shift=%0d want 1 0 0", in_ready, out_valid, shift_value);
        end
        for (int i = 0; i < 16; i++) begin
            vre[i] = 23'(i);
            vim[i] = '0;
        end
        vre[3] = 23'h0000FF;
        send_frame();
        checks++;
        if (shift_value !== ex(14) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_shift got %0d vld=%b want %0d 1", shift_value, out_valid, ex(14));
        end
        drain_all();
        checks++;
        if (ncap !== 16) begin
            errors++;
            $display("FAIL midrst_count got %0d want 16", ncap);
        end
        for (int i = 0; i < ncap; i++) begin
            checks++;
            if (cre[i] !== vre[i] || cim[i] !== vim[i]) begin
                errors++;
                $display("FAIL midrst_sample%0d got %h/%h want %h/%h", i, cre[i], cim[i], vre[i], vim[i]);
            end
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_extra got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_frame_fff();
        test_zero();
        test_neg_full();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
